cpx_dot_prod_acc: RTL
=====================

# cpx_dot_prod_acc

Parametrised, runtime-configurable complex dot-product engine for the CAF datapath: accepts paired complex samples x and y, forms x·y or x·conj(y) per sample, accumulates over a runtime-programmable frame length and emits one scaled complex result per frame. It is the successor to the fixed-length pipelined dot product. New capabilities: a synchronous reset, per-sample conjugation, full ready/valid backpressure on both sides, and an optional saturating output stage.

## Interface
- x_bits, 12: signed width of xi and xq.
- y_bits, 12: signed width of yi and yq.
- len_bits, 8: width of the length input; the maximum frame length is 2^len_bits − 1.
- prod_bits, x_bits+y_bits+1: full-precision width of each complex-product component.
- sum_bits, prod_bits+len_bits: accumulator width. Cannot overflow at any legal length.
- out_bits, 24: width of the i and q outputs.
- out_shift, sum_bits−out_bits: arithmetic right shift applied to the sum before output.

Ports:
- clk  in  1  sole clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- m_axis_tvalid  in  1  input sample pair valid.
- m_axis_tready  out  1  block can accept a sample this cycle.
- xi, xq  in  x_bits each  signed x sample.
- yi, yq  in  y_bits each  signed y sample.
- conj  in  1  per sample: 1 selects x·conj(y), 0 selects x·y.
- length  in  len_bits  frame length N. A value of 0 is treated as 1.
- s_axis_product_tvalid  out  1  result valid.
- s_axis_product_tready  in  1  downstream accepts the result.
- i, q  out  out_bits each  signed scaled result.

## Operation
- Acceptance occurs when m_axis_tvalid && m_axis_tready. xi, xq, yi, yq and conj are captured together.
- length is sampled only on acceptance of the first sample of a frame. Changes mid-frame have no effect until the next frame.
- Pipeline has three stages:
  - S1 registers the inputs.
  - S2 registers the four real products.
  - S3 forms the complex product:
    - re = xi·yi ∓ xq·yq
    - im = xq·yi ± xi·yq
    - The upper sign applies for conj=0, the lower for conj=1.
  - All arithmetic is signed. Products are sign-extended to sum_bits before accumulation.
- Accumulation:
  - The first product of a frame loads the accumulator; it does not add to it.
  - Products 2..N−1 add to the accumulator.
  - Product N is added combinationally and the result loads the output register directly. The accumulator is then free for the next frame with no bubble.
- Output value: i = (sum_re >>> out_shift) reduced to out_bits, and likewise q from sum_im.
  - Without the saturation macro, the reduction truncates to the low out_bits bits (wrap-around).
- Global stall: en = !(s_axis_product_tvalid && !s_axis_product_tready).
  - All pipeline stages, the counter and the accumulator advance only when en=1.
  - m_axis_tready = en && !rst.
- The output register holds i, q and valid stable until the handshake completes. tvalid drops after the handshake unless a new result loads in the same cycle.
- Reset effects:
  - Valid bits, frame counter and accumulator clear.
  - i, q and s_axis_product_tvalid are 0.
  - m_axis_tready is 0 during reset.
  - A partially accumulated frame is discarded. The first sample accepted after reset starts a new frame.

## Timing
- Latency: the last sample of a frame is accepted at edge T; s_axis_product_tvalid rises after edge T+3, provided no stall occurs. Stall cycles add one cycle each.
- Throughput:
  - One sample per cycle, with back-to-back frames and no idle cycles.
  - With N=1 and tready held at 1, one result is produced per cycle.
- Readiness: m_axis_tready is high on the first cycle after rst deasserts. It drops in the same cycle that the output is valid and not ready (combinational from s_axis_product_tready).
- Simultaneous events: when the output handshake and a new result load fall on the same edge, the new result replaces the old one and tvalid stays 1.
- Reset on any edge overrides all other activity on that edge.

## Configuration
- DOT_PROD_SAT_EN defined: after the shift, each component is clamped to [−2^(out_bits−1), 2^(out_bits−1)−1].
- DOT_PROD_SAT_EN undefined: after the shift, each component is truncated to its low out_bits bits. Latency is identical in both cases.

## Test plan
Unless stated otherwise, the bench uses out_shift=0 and s_axis_product_tready=1.
- N=4, x=(1,1), y=(2,−1), conj=0, 4 consecutive samples → i=12, q=4, valid exactly 3 cycles after the 4th acceptance. Repeating with conj=1 gives i=4, q=12.
- N=1, 8 back-to-back samples with x=(k,0), y=(1,0) for k=1..8 → 8 consecutive valid results i=1..8. m_axis_tready never drops.
- N=2 with s_axis_product_tready held at 0 for 5 cycles after the first result → m_axis_tready low in the same cycle; i and q stable. On release, no sample is lost or duplicated and all result values are correct.
- out_bits=16, N=16, x=y=(2047,0) → with DOT_PROD_SAT_EN, i=32767 and q=0. Without the macro, i=16 (67043344 mod 65536) and q=0.
- N=4: accept 2 samples, pulse rst for 1 cycle, then send 4 samples of x=(1,0), y=(1,0) → no output before the reset; one result afterwards with i=4, q=0.
- Start a frame with length=4, then drive length=2 after the first acceptance → the result covers 4 samples. The next frame uses N=2.

Source files
------------

// File: rtl/cpx_dot_prod_acc.sv
// -----------------------------------------------------------------------------
// cpx_dot_prod_acc
//
// Complex dot-product engine. It accepts paired complex samples x and y and
// forms x*y, or x*conj(y) when the per-sample conj bit is set. It accumulates
// these products over a frame whose length is programmed at run time, then
// emits one scaled complex result per frame.
//
// Configuration macro:
//   DOT_PROD_SAT_EN  When defined, the shifted sum is clamped to the signed
//                    out_bits range. When undefined, the shifted sum is
//                    truncated to its low out_bits bits (wrap-around).
//                    Latency is identical in both builds.
//
// Ports:
//   clk                    sole clock, rising edge
//   rst                    synchronous, active-high reset
//   m_axis_tvalid          input sample pair valid
//   m_axis_tready          block can accept a sample this cycle
//   xi, xq                 signed x sample (x_bits each)
//   yi, yq                 signed y sample (y_bits each)
//   conj                   1: x*conj(y), 0: x*y (captured with the sample)
//   length                 frame length N, sampled on the first sample of a
//                          frame (0 is treated as 1)
//   s_axis_product_tvalid  result valid
//   s_axis_product_tready  downstream accepts the result
//   i, q                   signed scaled result (out_bits each)
//
// Handshake semantics (both sides): a transfer happens on a rising edge where
// valid && ready are both 1. A producer holds valid and its data stable until
// that transfer. m_axis_tready is combinational from s_axis_product_tready,
// because the whole pipeline stalls while a result waits to be taken.
// -----------------------------------------------------------------------------
module cpx_dot_prod_acc #(
  parameter int x_bits    = 12,
  parameter int y_bits    = 12,
  parameter int len_bits  = 8,
  parameter int prod_bits = x_bits + y_bits + 1,
  parameter int sum_bits  = prod_bits + len_bits,
  parameter int out_bits  = 24,
  parameter int out_shift = sum_bits - out_bits
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       m_axis_tvalid,
  output logic                       m_axis_tready,
  input  logic signed [x_bits-1:0]   xi,
  input  logic signed [x_bits-1:0]   xq,
  input  logic signed [y_bits-1:0]   yi,
  input  logic signed [y_bits-1:0]   yq,
  input  logic                       conj,
  input  logic [len_bits-1:0]        length,
  output logic                       s_axis_product_tvalid,
  input  logic                       s_axis_product_tready,
  output logic signed [out_bits-1:0] i,
  output logic signed [out_bits-1:0] q
);

  // Width of a single real product.
  localparam int pw = x_bits + y_bits;

  // ---------------------------------------------------------------------------
  // Global stall and input acceptance
  // ---------------------------------------------------------------------------
  logic en;
  logic accept;

  // Everything freezes while a result is held and not yet taken.
  assign en            = !(s_axis_product_tvalid && !s_axis_product_tready);
  assign m_axis_tready = en && !rst;
  assign accept        = m_axis_tvalid && m_axis_tready;

  // ---------------------------------------------------------------------------
  // Frame counter
  // cnt == 0 means the next accepted sample opens a new frame. frame_len is
  // latched only on that first sample, so length changes mid-frame are
  // ignored until the next frame.
  // ---------------------------------------------------------------------------
  logic [len_bits-1:0] cnt;
  logic [len_bits-1:0] frame_len;
  logic [len_bits-1:0] len_eff;
  logic [len_bits-1:0] cnt_nxt;
  logic                first_in;
  logic                last_in;

  always_comb begin
    len_eff  = (length == '0) ? len_bits'(1) : length;
    first_in = (cnt == '0);
    if (first_in) begin
      last_in = (len_eff == len_bits'(1));
    end else begin
      last_in = (cnt == (frame_len - len_bits'(1)));
    end
    cnt_nxt = last_in ? '0 : (cnt + len_bits'(1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      frame_len <= '0;
    end else if (accept) begin
      cnt <= cnt_nxt;
      if (first_in) begin
        frame_len <= len_eff;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // S1: input registers
  // ---------------------------------------------------------------------------
  logic                     s1_valid;
  logic                     s1_first;
  logic                     s1_last;
  logic                     s1_conj;
  logic signed [x_bits-1:0] s1_xi;
  logic signed [x_bits-1:0] s1_xq;
  logic signed [y_bits-1:0] s1_yi;
  logic signed [y_bits-1:0] s1_yq;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
    end else if (en) begin
      s1_valid <= accept;
      s1_first <= first_in;
      s1_last  <= last_in;
    end
  end

  always_ff @(posedge clk) begin
    if (en && accept) begin
      s1_xi   <= xi;
      s1_xq   <= xq;
      s1_yi   <= yi;
      s1_yq   <= yq;
      s1_conj <= conj;
    end
  end

  // ---------------------------------------------------------------------------
  // S2: the four real products
  // Operands are sign-extended to the full product width first, so each
  // multiply is a same-width signed operation with no truncation.
  // ---------------------------------------------------------------------------
  logic signed [pw-1:0] xi_e;
  logic signed [pw-1:0] xq_e;
  logic signed [pw-1:0] yi_e;
  logic signed [pw-1:0] yq_e;

  assign xi_e = pw'(s1_xi);
  assign xq_e = pw'(s1_xq);
  assign yi_e = pw'(s1_yi);
  assign yq_e = pw'(s1_yq);

  logic                 s2_valid;
  logic                 s2_first;
  logic                 s2_last;
  logic                 s2_conj;
  logic signed [pw-1:0] s2_p_ii;
  logic signed [pw-1:0] s2_p_qq;
  logic signed [pw-1:0] s2_p_qi;
  logic signed [pw-1:0] s2_p_iq;

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_first <= 1'b0;
      s2_last  <= 1'b0;
    end else if (en) begin
      s2_valid <= s1_valid;
      s2_first <= s1_first;
      s2_last  <= s1_last;
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      s2_conj <= s1_conj;
      s2_p_ii <= xi_e * yi_e;
      s2_p_qq <= xq_e * yq_e;
      s2_p_qi <= xq_e * yi_e;
      s2_p_iq <= xi_e * yq_e;
    end
  end

  // ---------------------------------------------------------------------------
  // S3: complex product
  //   conj=0: re = ii - qq, im = qi + iq
  //   conj=1: re = ii + qq, im = qi - iq
  // ---------------------------------------------------------------------------
  logic signed [prod_bits-1:0] e_ii;
  logic signed [prod_bits-1:0] e_qq;
  logic signed [prod_bits-1:0] e_qi;
  logic signed [prod_bits-1:0] e_iq;
  logic signed [prod_bits-1:0] re_nxt;
  logic signed [prod_bits-1:0] im_nxt;

  always_comb begin
    e_ii = prod_bits'(s2_p_ii);
    e_qq = prod_bits'(s2_p_qq);
    e_qi = prod_bits'(s2_p_qi);
    e_iq = prod_bits'(s2_p_iq);
    if (s2_conj) begin
      re_nxt = e_ii + e_qq;
      im_nxt = e_qi - e_iq;
    end else begin
      re_nxt = e_ii - e_qq;
      im_nxt = e_qi + e_iq;
    end
  end

  logic                        s3_valid;
  logic                        s3_first;
  logic                        s3_last;
  logic signed [prod_bits-1:0] s3_re;
  logic signed [prod_bits-1:0] s3_im;

  always_ff @(posedge clk) begin
    if (rst) begin
      s3_valid <= 1'b0;
      s3_first <= 1'b0;
      s3_last  <= 1'b0;
    end else if (en) begin
      s3_valid <= s2_valid;
      s3_first <= s2_first;
      s3_last  <= s2_last;
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      s3_re <= re_nxt;
      s3_im <= im_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Accumulator
  // The first product of a frame loads, later ones add. The last product's sum
  // goes straight to the output register. The accumulator is therefore free on
  // the same edge, and the next frame starts with no bubble.
  // ---------------------------------------------------------------------------
  logic signed [sum_bits-1:0] acc_re;
  logic signed [sum_bits-1:0] acc_im;
  logic signed [sum_bits-1:0] re_ext;
  logic signed [sum_bits-1:0] im_ext;
  logic signed [sum_bits-1:0] sum_re;
  logic signed [sum_bits-1:0] sum_im;

  always_comb begin
    re_ext = sum_bits'(s3_re);
    im_ext = sum_bits'(s3_im);
    if (s3_first) begin
      sum_re = re_ext;
      sum_im = im_ext;
    end else begin
      sum_re = acc_re + re_ext;
      sum_im = acc_im + im_ext;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_re <= '0;
      acc_im <= '0;
    end else if (en && s3_valid && !s3_last) begin
      acc_re <= sum_re;
      acc_im <= sum_im;
    end
  end

  // ---------------------------------------------------------------------------
  // Output scaling: arithmetic shift, then either clamp or wrap to out_bits.
  // ---------------------------------------------------------------------------
`ifdef DOT_PROD_SAT_EN
  localparam logic signed [sum_bits-1:0] sat_max =
    {{(sum_bits - out_bits + 1){1'b0}}, {(out_bits - 1){1'b1}}};
  localparam logic signed [sum_bits-1:0] sat_min =
    {{(sum_bits - out_bits + 1){1'b1}}, {(out_bits - 1){1'b0}}};

  function automatic logic signed [out_bits-1:0] reduce(
    input logic signed [sum_bits-1:0] v
  );
    logic signed [sum_bits-1:0] sh;
    sh = v >>> out_shift;
    if (sh > sat_max) begin
      reduce = sat_max[out_bits-1:0];
    end else if (sh < sat_min) begin
      reduce = sat_min[out_bits-1:0];
    end else begin
      reduce = sh[out_bits-1:0];
    end
  endfunction
`else
  function automatic logic signed [out_bits-1:0] reduce(
    input logic signed [sum_bits-1:0] v
  );
    reduce = out_bits'(v >>> out_shift);
  endfunction
`endif

  // ---------------------------------------------------------------------------
  // Output register
  // A new result can only load while en=1. en=1 means the previous result was
  // either absent or taken on this same edge, so a load never overwrites an
  // untaken result.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      s_axis_product_tvalid <= 1'b0;
      i                     <= '0;
      q                     <= '0;
    end else if (en && s3_valid && s3_last) begin
      s_axis_product_tvalid <= 1'b1;
      i                     <= reduce(sum_re);
      q                     <= reduce(sum_im);
    end else if (s_axis_product_tready) begin
      s_axis_product_tvalid <= 1'b0;
    end
  end

endmodule
